// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between an upstream producer and the UART transmitter.
interface uart_tx_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] data;
   logic                      valid;
   logic                      ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_tx_bit_timer.sv
// Per-bit down-counter: tick marks the last clk cycle of each bit period.
module uart_bit_timer #(
   parameter int Oversample = 16
) (
   input  logic clk,
   input  logic nReset,
   input  logic restart,
   output logic tick
);

   localparam int CountW = (Oversample > 1) ? $clog2(Oversample) : 1;
   localparam logic [CountW-1:0] Reload = CountW'(Oversample - 1);

   logic [CountW-1:0] count;

   assign tick = (count == '0);

   // Count down, reloading at the end of each bit or whenever the FSM changes state.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         count <= Reload;
      end else if (restart || tick) begin
         count <= Reload;
      end else begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, one stop bit.
// Accepting during the last stop-bit cycle gives gap-free back-to-back frames.
module uart_tx
   import uart_pkg::*;
#(
   parameter int Oversample = 16
) (
   input  logic      clk,
   input  logic      nReset,
   uart_tx_if.slave  txIf,
   output logic      out,
   output logic      busy,
   output logic      done
);

   localparam int BitCountW = $clog2(UART_DATA_BITS);

   tx_state_t                 state, stateNext;
   logic [UART_DATA_BITS-1:0] shiftBuf, shiftNext;
   logic [BitCountW-1:0]      bitCount, bitCountNext;
   logic                      outNext;
   logic                      tick;
   logic                      restart;
   logic                      accept;

   assign txIf.ready = (state == IDLE) || ((state == STOP) && tick);
   assign accept     = txIf.valid && txIf.ready;
   assign busy       = (state != IDLE);
   assign done       = (state == STOP) && tick;
   assign restart    = (stateNext != state);

   uart_bit_timer #(.Oversample(Oversample)) bitTimer (
      .clk     (clk),
      .nReset  (nReset),
      .restart (restart),
      .tick    (tick)
   );

   // Next state, shift register and bit counter; the line level follows the next state.
   always_comb begin
      stateNext    = state;
      shiftNext    = shiftBuf;
      bitCountNext = bitCount;
      outNext      = 1'b1;
      case (state)
         IDLE: begin
            if (accept) begin
               stateNext = START;
               shiftNext = txIf.data;
            end
         end
         START: begin
            if (tick) begin
               stateNext    = DATA;
               bitCountNext = BitCountW'(UART_DATA_BITS - 1);
            end
         end
         DATA: begin
            if (tick) begin
               shiftNext = shiftBuf >> 1;
               if (bitCount == '0) begin
                  stateNext = STOP;
               end else begin
                  bitCountNext = bitCount - 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (accept) begin
                  stateNext = START;
                  shiftNext = txIf.data;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
      case (stateNext)
         START:   outNext = 1'b0;
         DATA:    outNext = shiftNext[0];
         default: outNext = 1'b1;
      endcase
   end

   // State, datapath and registered serial line; reset abandons any frame with the line high.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state    <= IDLE;
         shiftBuf <= '0;
         bitCount <= '0;
         out      <= 1'b1;
      end else begin
         state    <= stateNext;
         shiftBuf <= shiftNext;
         bitCount <= bitCountNext;
         out      <= outNext;
      end
   end

endmodule
